mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory port of the multicycle MIPS core between the
//  CPU control path (fetch/load/store accesses) and a debug/program loader.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 15 +
 rtl/mem_rr_arb2.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the unified memory port arbiter: FSM states and grant ids.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory access bundle; one instance each for the CPU and the loader.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin picker (bit 0 = CPU, bit 1 = loader) with an exclusion mask.
module mem_rr_arb2
    import mips_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       take,
    output logic       valid,
    output grant_t     gnt
);
    logic [1:0] cand;
    grant_t     last_q;
    grant_t     last_d;

    // On a tie the requester that was not served last time wins.
    always_comb begin
        cand  = req & ~mask;
        valid = |cand;
        gnt   = GNT_CPU;
        if (cand == 2'b11) begin
            gnt = (last_q == GNT_CPU) ? GNT_LDR : GNT_CPU;
        end else if (cand[1]) begin
            gnt = GNT_LDR;
        end
    end

    // Remember the winner only when the grant is actually taken.
    always_comb begin
        last_d = last_q;
        if (take && valid) begin
            last_d = gnt;
        end
    end

    // Starting at LDR makes the CPU win the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GNT_LDR;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the CPU control path and the debug loader.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              cclk,
    input  logic              rst,
    input  logic              halt,
    mem_port_arbiter_if.slave cpu,
    mem_port_arbiter_if.slave ldr,
    output logic              cpu_stall,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);
    localparam int CW = $clog2(MEM_LAT) + 1;

    state_t        state_q, state_d;
    grant_t        gnt_q, gnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;

    logic          arb_take;
    logic          arb_valid;
    grant_t        arb_gnt;
    logic          last_rd;

    assign arb_take = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign last_rd  = ((state_q == ST_ACCESS) && !we_q && (MEM_LAT == 1)) ||
                      ((state_q == ST_WAIT) && (cnt_q == CW'(MEM_LAT - 1)));

    mem_rr_arb2 u_arb (
        .clk   (cclk),
        .rst   (rst),
        .req   ({ldr.req, cpu.req & ~halt}),
        .mask  ({ldr.ack, cpu.ack}),
        .take  (arb_take),
        .valid (arb_valid),
        .gnt   (arb_gnt)
    );

    // Access sequencing, request latching and read-data capture.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (arb_valid) begin
                    state_d = ST_ACCESS;
                    gnt_d   = arb_gnt;
                    if (arb_gnt == GNT_CPU) begin
                        we_d    = cpu.we;
                        addr_d  = cpu.addr;
                        wdata_d = cpu.wdata;
                    end else begin
                        we_d    = ldr.we;
                        addr_d  = ldr.addr;
                        wdata_d = ldr.wdata;
                    end
                end
            end
            ST_ACCESS: begin
                if (we_q || (MEM_LAT == 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(MEM_LAT - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (last_rd) begin
            if (gnt_q == GNT_CPU) begin
                cpu_rdata_d = mem_rdata;
            end else begin
                ldr_rdata_d = mem_rdata;
            end
        end
    end

    // State and data registers; reset abandons any access in flight.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_we    = (state_q == ST_ACCESS) && we_q;
    assign mem_re    = ((state_q == ST_ACCESS) || (state_q == ST_WAIT)) && !we_q;
    assign mem_addr  = busy ? (addr_q & ~AW'(3)) : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign cpu.ack   = (state_q == ST_DONE) && (gnt_q == GNT_CPU);
    assign ldr.ack   = (state_q == ST_DONE) && (gnt_q == GNT_LDR);
    assign cpu.rdata = cpu_rdata_q;
    assign ldr.rdata = ldr_rdata_q;
    assign cpu_stall = cpu.req & ~cpu.ack;
endmodule
